// File: rtl/rf_ctrl_pkg.sv
// Shared types and default widths for the register-file access controller.
package rf_ctrl_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 3;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_MOVE  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RESP,
    MV_RD,
    MV_WR,
    CLR
  } state_t;

endpackage

// File: rtl/rf_access_ctrl_if.sv
// Command and response channels between a host and the register-file access controller.
interface rf_access_ctrl_if
  import rf_ctrl_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  op_t           cmd_op;
  logic [AW-1:0] cmd_dst;
  logic [AW-1:0] cmd_src;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/rf_access_ctrl.sv
// Sequences write/read/move/clear commands onto the 8x8 register file pins
// and returns read data over a valid/ready response channel.
module rf_access_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic             clk,
  input  logic             rst,
  rf_access_ctrl_if.slave  bus,
  output logic [DW-1:0]    rf_I,
  output logic             rf_WE,
  output logic [AW-1:0]    rf_WA,
  output logic             rf_RE,
  output logic [AW-1:0]    rf_RA,
  input  logic [DW-1:0]    rf_O,
  output logic             busy
);

  localparam int NREG = 2 ** AW;

  state_t        state, state_n;
  logic [AW-1:0] dst_q, src_q, cnt;
  logic [DW-1:0] data_q, rsp_q;
  logic [AW-1:0] wa_hold, ra_hold;
  logic [DW-1:0] i_hold;
  logic          accept;

  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign bus.cmd_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_q;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Idle pins keep the last driven address/data so the file never sees X.
  always_comb begin
    state_n = state;
    rf_WE   = 1'b0;
    rf_RE   = 1'b0;
    rf_WA   = wa_hold;
    rf_RA   = ra_hold;
    rf_I    = i_hold;
    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_WRITE: state_n = WR;
            OP_READ:  state_n = RD;
            OP_MOVE:  state_n = (bus.cmd_dst == bus.cmd_src) ? CLR : MV_RD;
            default:  state_n = IDLE;
          endcase
        end
      end
      WR: begin
        rf_WE   = 1'b1;
        rf_WA   = dst_q;
        rf_I    = data_q;
        state_n = IDLE;
      end
      RD: begin
        rf_RE   = 1'b1;
        rf_RA   = dst_q;
        state_n = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_n = IDLE;
      end
      MV_RD: begin
        rf_RE   = 1'b1;
        rf_RA   = src_q;
        state_n = MV_WR;
      end
      MV_WR: begin
        rf_WE   = 1'b1;
        rf_WA   = dst_q;
        rf_I    = data_q;
        state_n = IDLE;
      end
      CLR: begin
        rf_WE = 1'b1;
        rf_WA = cnt;
        rf_I  = '0;
        if (cnt == AW'(NREG - 1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // The clear counter wraps naturally to 0 on the last register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_q   <= '0;
      src_q   <= '0;
      data_q  <= '0;
      rsp_q   <= '0;
      cnt     <= '0;
      wa_hold <= '0;
      ra_hold <= '0;
      i_hold  <= '0;
    end else begin
      wa_hold <= rf_WA;
      ra_hold <= rf_RA;
      i_hold  <= rf_I;
      if (accept) begin
        dst_q  <= bus.cmd_dst;
        src_q  <= bus.cmd_src;
        data_q <= bus.cmd_data;
      end
      if (state == RD)    rsp_q  <= rf_O;
      if (state == MV_RD) data_q <= rf_O;
      if (state == CLR)   cnt    <= cnt + AW'(1);
    end
  end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Self-checking bench for rf_access_ctrl with a behavioural register file as its load.
module tb_rf_access_ctrl;
  import rf_ctrl_pkg::*;

  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int NREG = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_access_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  logic [DW-1:0] rf_I, rf_O;
  logic          rf_WE, rf_RE, busy;
  logic [AW-1:0] rf_WA, rf_RA;

  rf_access_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .rf_I  (rf_I),
    .rf_WE (rf_WE),
    .rf_WA (rf_WA),
    .rf_RE (rf_RE),
    .rf_RA (rf_RA),
    .rf_O  (rf_O),
    .busy  (busy)
  );

  // Register file load: synchronous write, combinational read, no reset.
  logic [DW-1:0] rf_mem [NREG];
  always @(posedge clk) if (rf_WE) rf_mem[rf_WA] <= rf_I;
  assign rf_O = rf_RE ? rf_mem[rf_RA] : '0;

  logic [DW-1:0] ref_mem [NREG];
  logic [DW-1:0] saved_mem [NREG];
  logic [DW-1:0] exp_q [$];
  int checks   = 0;
  int failures = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input op_t op, input logic [AW-1:0] dst, input logic [AW-1:0] src,
                                input logic [DW-1:0] data);
    bit got = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL cmd_accept_timeout actual=ready_low required=ready_high");
      return;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_dst   = dst;
    bus.cmd_src   = src;
    bus.cmd_data  = data;
    case (op)
      OP_WRITE: ref_mem[dst] = data;
      OP_READ:  exp_q.push_back(ref_mem[dst]);
      OP_MOVE: begin
        if (dst == src) for (int i = 0; i < NREG; i++) ref_mem[i] = '0;
        else ref_mem[dst] = ref_mem[src];
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Scoreboard monitor: pops an expectation on every response handshake.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (rf_WE && rf_RE) begin
        failures++;
        $display("[TB] FAIL we_re_overlap actual=1 required=0");
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_rsp actual=%0h required=none", bus.rsp_data);
        end else begin
          check_output("rsp_data", 32'(bus.rsp_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int we_cnt;
    op_t rop;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_dst   = '0;
    bus.cmd_src   = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NREG; i++) ref_mem[i] = '0;

    @(posedge clk);
    #1;
    check_output("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check_output("rst_rsp_data",  32'(bus.rsp_data), 0);
    check_output("rst_we",        32'(rf_WE), 0);
    check_output("rst_re",        32'(rf_RE), 0);
    check_output("rst_wa",        32'(rf_WA), 0);
    check_output("rst_ra",        32'(rf_RA), 0);
    check_output("rst_i",         32'(rf_I), 0);
    check_output("rst_busy",      32'(busy), 0);
    check_output("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    // WRITE then READ of r3
    apply_stimulus(OP_WRITE, 3'd3, 3'd0, 8'hA5);
    check_output("wr_we", 32'(rf_WE), 1);
    check_output("wr_wa", 32'(rf_WA), 3);
    check_output("wr_i",  32'(rf_I), 'hA5);
    check_output("wr_re", 32'(rf_RE), 0);
    @(posedge clk); #1;
    check_output("wr_we_pulse", 32'(rf_WE), 0);
    check_output("wr_wa_hold",  32'(rf_WA), 3);
    check_output("wr_ready",    32'(bus.cmd_ready), 1);
    apply_stimulus(OP_READ, 3'd3, 3'd0, 8'h00);
    check_output("rd_re",       32'(rf_RE), 1);
    check_output("rd_ra",       32'(rf_RA), 3);
    check_output("rd_rsp_early", 32'(bus.rsp_valid), 0);
    @(posedge clk); #1;
    check_output("rd_rsp_valid", 32'(bus.rsp_valid), 1);
    check_output("rd_re_off",    32'(rf_RE), 0);
    @(posedge clk); #1;
    check_output("rd_ready_back", 32'(bus.cmd_ready), 1);
    check_output("rd_rsp_done",   32'(bus.rsp_valid), 0);

    // READ with response back-pressure
    apply_stimulus(OP_WRITE, 3'd5, 3'd0, 8'h5A);
    bus.rsp_ready = 1'b0;
    apply_stimulus(OP_READ, 3'd5, 3'd0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check_output("bp_rsp_valid", 32'(bus.rsp_valid), 1);
      check_output("bp_rsp_data",  32'(bus.rsp_data), 'h5A);
      check_output("bp_cmd_ready", 32'(bus.cmd_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_output("bp_ready_back", 32'(bus.cmd_ready), 1);

    // MOVE r1 -> r6
    apply_stimulus(OP_WRITE, 3'd1, 3'd0, 8'h3C);
    apply_stimulus(OP_MOVE, 3'd6, 3'd1, 8'h00);
    check_output("mv_busy0", 32'(busy), 1);
    check_output("mv_re",    32'(rf_RE), 1);
    check_output("mv_ra",    32'(rf_RA), 1);
    check_output("mv_rsp0",  32'(bus.rsp_valid), 0);
    @(posedge clk); #1;
    check_output("mv_busy1", 32'(busy), 1);
    check_output("mv_we",    32'(rf_WE), 1);
    check_output("mv_wa",    32'(rf_WA), 6);
    check_output("mv_i",     32'(rf_I), 'h3C);
    check_output("mv_rsp1",  32'(bus.rsp_valid), 0);
    @(posedge clk); #1;
    check_output("mv_idle",  32'(busy), 0);
    apply_stimulus(OP_READ, 3'd6, 3'd0, 8'h00);

    // Fill then full CLEAR
    for (int i = 0; i < NREG; i++) apply_stimulus(OP_WRITE, AW'(i), 3'd0, DW'((i + 1) * 17));
    apply_stimulus(OP_MOVE, 3'd0, 3'd0, 8'h00);
    we_cnt = 0;
    for (int i = 0; i < NREG; i++) begin
      check_output("clr_wa", 32'(rf_WA), 32'(i));
      check_output("clr_i",  32'(rf_I), 0);
      if (rf_WE) we_cnt++;
      @(posedge clk); #1;
    end
    check_output("clr_we_cycles", 32'(we_cnt), 8);
    check_output("clr_we_end",    32'(rf_WE), 0);
    check_output("clr_idle",      32'(busy), 0);
    for (int i = 0; i < NREG; i++) apply_stimulus(OP_READ, AW'(i), 3'd0, 8'h00);

    // Reset in the middle of a CLEAR at cnt==4
    for (int i = 0; i < NREG; i++) apply_stimulus(OP_WRITE, AW'(i), 3'd0, DW'((i + 1) * 17));
    for (int i = 0; i < NREG; i++) saved_mem[i] = ref_mem[i];
    apply_stimulus(OP_MOVE, 3'd2, 3'd2, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    check_output("clr4_wa", 32'(rf_WA), 4);
    check_output("clr4_we", 32'(rf_WE), 1);
    rst = 1'b1;
    #1;
    check_output("arst_we",    32'(rf_WE), 0);
    check_output("arst_wa",    32'(rf_WA), 0);
    check_output("arst_i",     32'(rf_I), 0);
    check_output("arst_busy",  32'(busy), 0);
    check_output("arst_ready", 32'(bus.cmd_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 4; i < NREG; i++) ref_mem[i] = saved_mem[i];
    for (int i = 0; i < NREG; i++) apply_stimulus(OP_READ, AW'(i), 3'd0, 8'h00);

    // Random op/address stream against the reference model
    for (int n = 0; n < 40; n++) begin
      rop = op_t'($urandom_range(0, 3));
      apply_stimulus(rop, AW'($urandom_range(0, NREG - 1)), AW'($urandom_range(0, NREG - 1)),
                     DW'($urandom_range(0, 255)));
    end

    repeat (12) @(posedge clk);
    #1;
    check_output("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_access_ctrl.md
# rf_access_ctrl

Command-driven access controller that acts as the initiator for the 8×8 register file. It accepts write, read, move and clear commands over a valid/ready interface and sequences the register file's write-enable/address and read-enable/address pins. It captures read data from the register file's output bus and returns it over a valid/ready response channel. It sits between a host or datapath sequencer and the register file.

## Interface
Parameters:
- DW, 8, data width; matches the register file word.
- AW, 3, address width; register count NREG = 2**AW.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command (high only in IDLE).
- cmd_op  input  2  operation:
  - 00 NOP
  - 01 WRITE
  - 10 READ
  - 11 MOVE; CLEAR is encoded as MOVE with cmd_dst == cmd_src.
- cmd_dst  input  AW  destination address (WRITE, MOVE) or read address (READ).
- cmd_src  input  AW  source address (MOVE).
- cmd_data  input  DW  write data (WRITE).
- rsp_valid  output  1  read data available.
- rsp_ready  input  1  consumer accepts read data.
- rsp_data  output  DW  captured read data.
- rf_I  output  DW  register file write data.
- rf_WE  output  1  register file write enable.
- rf_WA  output  AW  register file write address.
- rf_RE  output  1  register file read enable.
- rf_RA  output  AW  register file read address.
- rf_O  input  DW  register file read bus (combinational, valid in the same cycle as rf_RE).
- busy  output  1  high in any state other than IDLE.

## Operation
- Handshake: a command is accepted on a rising edge where cmd_valid && cmd_ready. The controller latches op, dst, src and data.
- NOP: accepted; the FSM stays in IDLE.
- States:
  - IDLE: cmd_ready=1. On accept, go to WR, RD, MV_RD or CLR per the op (MOVE with dst==src goes to CLR).
  - WR: rf_WE=1, rf_WA=dst, rf_I=data for one cycle, then go to IDLE.
  - RD: rf_RE=1, rf_RA=dst. rsp_data <= rf_O at the end of the cycle. Go to RESP.
  - RESP: rsp_valid=1 and rsp_data held until rsp_ready. Go to IDLE on the edge where rsp_valid && rsp_ready.
  - MV_RD: rf_RE=1, rf_RA=src. The data register <= rf_O. Go to MV_WR.
  - MV_WR: rf_WE=1, rf_WA=dst, rf_I=data register. Go to IDLE. MOVE produces no response.
  - CLR: counter cnt starts at 0. Each cycle drives rf_WE=1, rf_WA=cnt, rf_I=0. The state exits to IDLE after the cycle with cnt==NREG-1, and cnt wraps to 0.
- Pin rules:
  - rf_WE and rf_RE are never high in the same cycle.
  - In every state where a pin is not used, rf_WE=0 and rf_RE=0.
  - Addresses and rf_I are held at their last value, never X.
- Reset:
  - State IDLE, cnt=0, data register 0.
  - Output reset values: rsp_data=0, rsp_valid=0, rf_WE=0, rf_RE=0, rf_WA=0, rf_RA=0, rf_I=0, busy=0, cmd_ready=1.
- Reset mid-operation: the operation is aborted immediately.
  - A write whose edge has not yet occurred does not happen.
  - An interrupted CLEAR leaves registers 0..cnt-1 cleared and the rest untouched.
  - A pending response is dropped.

## Timing
Edge E0 is the command accept edge.
- WRITE: WE high in cycle E0–E1; register updated at E1; cmd_ready high again after E1. Throughput: 1 write per 2 cycles.
- READ: RE high in cycle E0–E1; rsp_valid high from E1. With rsp_ready tied high, RESP lasts one cycle and cmd_ready returns after E2.
- MOVE: read in E0–E1, write in E1–E2; destination updated at E2; idle after E2.
- CLEAR: 8 write cycles (E0–E8) with WA = 0,1,…,7; idle after E8.
- Back-pressure: rsp_ready low holds RESP indefinitely; no new command is accepted in that time.

## Structure
- Shared package rf_ctrl_pkg:
  - op_t enum (OP_NOP, OP_WRITE, OP_READ, OP_MOVE).
  - state_t enum (IDLE, WR, RD, RESP, MV_RD, MV_WR, CLR).
  - Default DW and AW constants.
- Single module with no sub-module: the FSM, counter and data register are small.
- Benches instantiate the existing register file as the load to close the loop.

## Test plan
- Reset then WRITE dst=3 data=0xA5, then READ dst=3 → rf_WE pulses one cycle with WA=3; rsp_valid rises the cycle after RE; rsp_data=0xA5.
- READ dst=5 with rsp_ready low for 4 cycles → rsp_valid and rsp_data held stable; cmd_ready=0 throughout; cmd_ready returns one cycle after rsp_ready rises.
- WRITE r1=0x3C, then MOVE src=1 dst=6, then READ 6 → rsp_data=0x3C; no rsp_valid during MOVE; MOVE busy for exactly 2 cycles.
- Fill r0..r7 with 0x11..0x88, then CLEAR (MOVE dst=src=0) → exactly 8 WE cycles with WA 0→7; all 8 reads return 0x00.
- Assert rst during CLR when cnt=4 → outputs immediately reach their reset values; r0..r3=0; r4..r7 retain their old values; first command after reset is accepted.
- Random op/address stream with a checker → a reference model matches every rsp_data; rf_WE && rf_RE is never high together.
